// File: rtl/debounce_edge_gen_if.sv
// Signal bundle between a raw-input source and the debounce/edge stage.
// The master drives the raw level and enable; the slave returns the clean level and status.
interface debounce_edge_gen_if #(
  parameter int GLITCH_W = 8
);
  logic                din_async;
  logic                en;
  logic                dout;
  logic                rise_pulse;
  logic                fall_pulse;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output din_async, en,
    input  dout, rise_pulse, fall_pulse, busy, glitch_cnt
  );

  modport slave (
    input  din_async, en,
    output dout, rise_pulse, fall_pulse, busy, glitch_cnt
  );
endinterface

// File: rtl/debounce_edge_gen.sv
// Synchronizes a raw level, accepts a change only after STABLE_CYCLES stable cycles,
// and emits registered clean level, rise/fall pulses, busy and a saturating glitch count.
module debounce_edge_gen #(
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 1000,
  parameter int GLITCH_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  debounce_edge_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_TERM   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  state_t              state_q, state_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                dout_q, dout_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                busy_q, busy_d;
  logic [GLITCH_W-1:0] glitch_inc;

  assign glitch_inc = (glitch_q == GLITCH_MAX) ? glitch_q : glitch_q + GLITCH_ONE;

  always_comb begin
    s1_d     = bus.din_async;
    s2_d     = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;

    // Disable beats abort, and abort beats terminal count.
    case (state_q)
      IDLE_LO: begin
        if (bus.en && s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!bus.en) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (!s2_q) begin
          state_d  = IDLE_LO;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_TERM) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (bus.en && !s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (!bus.en) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (s2_q) begin
          state_d  = IDLE_HI;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_TERM) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase

    // Level and busy are decoded from the next state so they register alongside it.
    dout_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE_LO;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      glitch_q <= '0;
      dout_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;
  assign bus.glitch_cnt = glitch_q;

endmodule

// File: doc/debounce_edge_gen.md
Name: debounce_edge_gen

Overview:
- Conditioning stage that sits directly upstream of the team's D flip-flop cell and drives its d input.
- Takes a raw asynchronous level (switch/button/external pin) and synchronizes it into clk.
- Filters bounce by requiring a programmable number of consecutive stable cycles before the clean level changes.
- Emits single-cycle rise/fall pulses alongside the clean level for downstream registers and counters.

Parameters:
- CNT_W, 16, width of the stability counter.
- STABLE_CYCLES, 1000, consecutive synchronized cycles required to accept a level change. Legal range: 2 <= STABLE_CYCLES <= 2^CNT_W - 1.
- GLITCH_W, 8, width of the saturating rejected-glitch counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately while low.
- din_async  input  1  raw asynchronous input level.
- en  input  1  filter enable; when 0 the filter is frozen.
- dout  output  1  debounced, synchronized level (feeds the D flip-flop d input).
- rise_pulse  output  1  one-cycle pulse on an accepted 0->1 change of dout.
- fall_pulse  output  1  one-cycle pulse on an accepted 1->0 change of dout.
- busy  output  1  high while a candidate change is being qualified.
- glitch_cnt  output  GLITCH_W  number of aborted candidate changes; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops s1 and s2 = 0; counter = 0; FSM = IDLE_LO.
  - dout = 0, rise_pulse = 0, fall_pulse = 0, busy = 0, glitch_cnt = 0.
  - Reset asserted mid-qualification aborts the qualification without a pulse and without incrementing glitch_cnt.
- Synchronizer: two-flop chain, s1 <= din_async, s2 <= s1. It runs every cycle regardless of en. Only s2 is used downstream.
- FSM states:
  - IDLE_LO: dout=0. If en and s2=1, go to WAIT_HI with cnt <= 1.
  - WAIT_HI: dout=0, busy=1.
    - If s2=0: go to IDLE_LO, cnt <= 0, increment glitch_cnt.
    - Else if cnt == STABLE_CYCLES-1: go to IDLE_HI, dout <= 1, rise_pulse <= 1, cnt <= 0.
    - Else cnt <= cnt+1.
  - IDLE_HI: dout=1. If en and s2=0, go to WAIT_LO with cnt <= 1.
  - WAIT_LO: mirror of WAIT_HI. Abort on s2=1 back to IDLE_HI with a glitch_cnt increment; accept by going to IDLE_LO with dout <= 0 and fall_pulse <= 1.
- Outputs are registered:
  - busy = 1 exactly in the WAIT states.
  - Each pulse is high for exactly one cycle, on the cycle after the edge that changes dout, coincident with the new dout value.
- Latency: a din_async change captured at edge k (first edge at which s1 takes the new value) makes dout change at edge k+STABLE_CYCLES+1. This holds provided the input stays stable and en=1 throughout.
- en=0:
  - Any WAIT state returns to its IDLE state at the next edge with cnt=0.
  - No pulse is generated and glitch_cnt is not incremented.
  - dout holds its value; IDLE transitions are inhibited.
  - When en returns to 1, qualification restarts from a count of 1.
- glitch_cnt saturates at 2^GLITCH_W-1 and never wraps.
- Simultaneous abort and terminal count cannot occur: the abort check has priority, so a mismatching s2 on the terminal cycle aborts.
- No combinational path from din_async or en to any output.

Test Plan (STABLE_CYCLES=4 for simulation):
- Reset then din_async=0 held for 20 cycles -> dout=0, no pulses, busy=0, glitch_cnt=0.
- din_async 0->1 captured at edge k and held -> busy=1 from edge k+2; dout=1 and rise_pulse=1 (single cycle) at edge k+5; busy=0 after edge k+5.
- From dout=1, din_async toggles 1->0->1 with a 2-cycle low glitch -> dout stays 1, fall_pulse never asserts, glitch_cnt increments to 1.
- Apply 300 glitches of 1-2 cycles -> glitch_cnt saturates at 255 and holds; dout never changes.
- en=0 with din_async stepped 0->1 and held 10 cycles -> dout stays 0, busy=0. Raise en -> dout=1 with rise_pulse exactly 4 cycles later.
- rst pulsed low mid-WAIT_HI (cnt=2) -> all outputs 0 immediately while low. After release with din_async=1 held, rise_pulse occurs STABLE_CYCLES+2 edges later.
